// File: rtl/updi_reg_pkg.sv
// Shared types and constants for the UPDI control/status register bank:
// access types, unlock key value, default masks and the UPDI register map.
package updi_reg_pkg;

  typedef enum logic [1:0] {
    ACC_RW  = 2'd0,
    ACC_RO  = 2'd1,
    ACC_W1C = 2'd2
  } acc_e;

  localparam logic [7:0]  UPDI_KEY_VAL = 8'hC5;
  localparam int          UPDI_NUM_REGS = 13;

  localparam logic [12:0] UPDI_DEF_RO_MASK   = 13'h0000;
  localparam logic [12:0] UPDI_DEF_W1C_MASK  = 13'h0000;
  localparam logic [12:0] UPDI_DEF_PROT_MASK = 13'h0000;

  localparam logic [3:0] UPDI_STATUSA         = 4'h0;
  localparam logic [3:0] UPDI_STATUSB         = 4'h1;
  localparam logic [3:0] UPDI_CTRLA           = 4'h2;
  localparam logic [3:0] UPDI_CTRLB           = 4'h3;
  localparam logic [3:0] UPDI_ASI_KEY_STATUS  = 4'h7;
  localparam logic [3:0] UPDI_ASI_RESET_REQ   = 4'h8;
  localparam logic [3:0] UPDI_ASI_CTRLA       = 4'h9;
  localparam logic [3:0] UPDI_ASI_SYS_CTRLA   = 4'hA;
  localparam logic [3:0] UPDI_ASI_SYS_STATUS  = 4'hB;
  localparam logic [3:0] UPDI_ASI_CRC_STATUS  = 4'hC;
  localparam logic [3:0] UPDI_KEY_ADDR        = 4'hC;

  // Read-only wins over write-1-to-clear when both mask bits are set.
  function automatic acc_e acc_of(input logic ro, input logic w1c);
    if (ro)  return ACC_RO;
    if (w1c) return ACC_W1C;
    return ACC_RW;
  endfunction

endpackage

// File: rtl/updi_reg_bank_if.sv
// Port-0 CPU-style access bus between the UPDI instruction decoder (master)
// and the register bank (slave).
interface updi_reg_bank_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  csb0;
  logic                  web0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;
  logic                  rvalid0;
  logic                  aerr0;

  modport master (
    output csb0, web0, addr0, din0,
    input  dout0, rvalid0, aerr0
  );

  modport slave (
    input  csb0, web0, addr0, din0,
    output dout0, rvalid0, aerr0
  );
endinterface

// File: rtl/updi_reg_cell.sv
// One UPDI register: RW holds written data, W1C collects sticky hardware
// flags cleared by writing 1, RO simply mirrors its live hardware value.
module updi_reg_cell
  import updi_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter acc_e                  ACC        = ACC_RW,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] hw_set,
  input  logic [DATA_WIDTH-1:0] hw_ro_val,
  output logic [DATA_WIDTH-1:0] val
);

  if (ACC == ACC_RO) begin : g_ro
    assign val = hw_ro_val;
    wire unused_ro = ^{clk0, rst0_n, we, wdata, hw_set};
  end else begin : g_stored
    logic [DATA_WIDTH-1:0] val_q, val_d;

    // Set is applied after the clear so a same-cycle set/clear leaves the bit set.
    always_comb begin
      val_d = val_q;
      if (ACC == ACC_W1C) begin
        if (we) val_d = val_q & ~wdata;
        val_d = val_d | hw_set;
      end else if (we) begin
        val_d = wdata;
      end
    end

    always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) val_q <= RESET_VAL;
      else         val_q <= val_d;
    end

    assign val = val_q;
    wire unused_stored = ^{hw_ro_val, hw_set};
  end

endmodule

// File: rtl/updi_reg_bank.sv
// Parametrised UPDI control/status register bank with a two-stage port-0
// pipeline. Optional key-based write lock enabled by define UPDI_REG_LOCK_EN.
module updi_reg_bank
  import updi_reg_pkg::*;
#(
  parameter int                              DATA_WIDTH    = 8,
  parameter int                              ADDR_WIDTH    = 4,
  parameter int                              RAM_DEPTH     = 13,
  parameter logic [RAM_DEPTH-1:0]            RO_MASK       = '0,
  parameter logic [RAM_DEPTH-1:0]            W1C_MASK      = '0,
  parameter logic [RAM_DEPTH*DATA_WIDTH-1:0] RESET_VAL     = '0,
  parameter logic [ADDR_WIDTH-1:0]           KEY_ADDR      = ADDR_WIDTH'(4'hC),
  parameter logic [RAM_DEPTH-1:0]            PROT_MASK     = '0,
  parameter int                              UNLOCK_CYCLES = 16
) (
  input  logic                              clk0,
  input  logic                              rst0_n,
  updi_reg_bank_if.slave                    bus,
  input  logic [RAM_DEPTH*DATA_WIDTH-1:0]   hw_set,
  input  logic [RAM_DEPTH*DATA_WIDTH-1:0]   hw_ro_val,
  output logic [RAM_DEPTH*DATA_WIDTH-1:0]   reg_q,
  output logic                              locked0
);

  logic                  req_vld_q, req_vld_d;
  logic                  req_we_q, req_we_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] req_din_q, req_din_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  rvalid_q, rvalid_d;
  logic                  aerr_q, aerr_d;

  logic [DATA_WIDTH-1:0] cell_val [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [RAM_DEPTH-1:0]  wr_en;
  logic [RAM_DEPTH-1:0]  prot_block;
  logic                  in_range;
  logic                  key_sel;
  logic                  locked_int;

  always_comb begin
    req_vld_d  = ~bus.csb0;
    req_we_d   = ~bus.web0;
    req_addr_d = bus.addr0;
    req_din_d  = bus.din0;
  end

  assign in_range = (int'(req_addr_q) < RAM_DEPTH);

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < RAM_DEPTH; i++) begin
      if (int'(req_addr_q) == i) rd_word = cell_val[i];
    end
    if (key_sel) rd_word = {{(DATA_WIDTH-1){1'b0}}, locked_int};
  end

  always_comb begin
    dout_d   = dout_q;
    rvalid_d = 1'b0;
    aerr_d   = 1'b0;
    wr_en    = '0;
    if (req_vld_q) begin
      if (!in_range) begin
        aerr_d = 1'b1;
        if (!req_we_q) begin
          rvalid_d = 1'b1;
          dout_d   = '0;
        end
      end else if (!req_we_q) begin
        rvalid_d = 1'b1;
        dout_d   = rd_word;
      end else if (!key_sel) begin
        for (int i = 0; i < RAM_DEPTH; i++) begin
          if (int'(req_addr_q) == i) begin
            if (RO_MASK[i] || prot_block[i]) aerr_d   = 1'b1;
            else                             wr_en[i] = 1'b1;
          end
        end
      end
    end
  end

`ifdef UPDI_REG_LOCK_EN
  localparam int CNT_W = $clog2(UNLOCK_CYCLES + 1);

  logic [CNT_W-1:0] win_q, win_d;
  logic             key_wr;
  logic             prot_wr;

  assign key_sel    = (req_addr_q == KEY_ADDR);
  assign locked_int = (win_q == '0);
  assign prot_block = PROT_MASK & {RAM_DEPTH{locked_int}};
  assign key_wr     = req_vld_q & req_we_q & key_sel;
  assign prot_wr    = |(wr_en & PROT_MASK);

  // The window is open exactly while the counter is non-zero.
  always_comb begin
    win_d = win_q;
    if (win_q != '0) win_d = win_q - CNT_W'(1);
    if (key_wr) begin
      win_d = (req_din_q == DATA_WIDTH'(UPDI_KEY_VAL)) ? CNT_W'(UNLOCK_CYCLES) : '0;
    end else if (prot_wr) begin
      win_d = '0;
    end
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) win_q <= '0;
    else         win_q <= win_d;
  end
`else
  assign key_sel    = 1'b0;
  assign locked_int = 1'b0;
  assign prot_block = '0;
  wire unused_lock_cfg = ^{KEY_ADDR, PROT_MASK, 32'(UNLOCK_CYCLES)};
`endif

  assign locked0 = locked_int;

  for (genvar i = 0; i < RAM_DEPTH; i++) begin : g_cell
    updi_reg_cell #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC        (acc_of(RO_MASK[i], W1C_MASK[i])),
      .RESET_VAL  (RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH])
    ) u_cell (
      .clk0      (clk0),
      .rst0_n    (rst0_n),
      .we        (wr_en[i]),
      .wdata     (req_din_q),
      .hw_set    (hw_set[i*DATA_WIDTH +: DATA_WIDTH]),
      .hw_ro_val (hw_ro_val[i*DATA_WIDTH +: DATA_WIDTH]),
      .val       (cell_val[i])
    );
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = cell_val[i];
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      req_vld_q  <= 1'b0;
      req_we_q   <= 1'b0;
      req_addr_q <= '0;
      req_din_q  <= '0;
      dout_q     <= '0;
      rvalid_q   <= 1'b0;
      aerr_q     <= 1'b0;
    end else begin
      req_vld_q  <= req_vld_d;
      req_we_q   <= req_we_d;
      req_addr_q <= req_addr_d;
      req_din_q  <= req_din_d;
      dout_q     <= dout_d;
      rvalid_q   <= rvalid_d;
      aerr_q     <= aerr_d;
    end
  end

  assign bus.dout0   = dout_q;
  assign bus.rvalid0 = rvalid_q;
  assign bus.aerr0   = aerr_q;

endmodule

// File: tb/tb_updi_reg_bank.sv
// Self-checking bench for updi_reg_bank: directed steps followed by random
// traffic, compared each cycle against a register-level behavioural model.
`timescale 1ns/1ps
module tb_updi_reg_bank;
  import updi_reg_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int ND = 13;
  localparam int W  = ND * DW;
  localparam logic [ND-1:0] RO_M   = 13'h0041;
  localparam logic [ND-1:0] W1C_M  = 13'h0012;
  localparam logic [ND-1:0] PROT_M = 13'h0020;
  localparam logic [W-1:0]  RST_IMG = (W'(8'h10) << 24) | (W'(8'h01) << 32) | (W'(8'h77) << 56);
  localparam int UNLOCK = 16;
  localparam int KEY_A  = 12;

  logic         clk0 = 1'b0;
  logic         rst0_n = 1'b0;
  logic [W-1:0] hw_set = '0;
  logic [W-1:0] hw_ro_val = '0;
  logic [W-1:0] reg_q;
  logic         locked0;

  updi_reg_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  updi_reg_bank #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .RAM_DEPTH     (ND),
    .RO_MASK       (RO_M),
    .W1C_MASK      (W1C_M),
    .RESET_VAL     (RST_IMG),
    .KEY_ADDR      (4'hC),
    .PROT_MASK     (PROT_M),
    .UNLOCK_CYCLES (UNLOCK)
  ) dut (
    .clk0      (clk0),
    .rst0_n    (rst0_n),
    .bus       (bus),
    .hw_set    (hw_set),
    .hw_ro_val (hw_ro_val),
    .reg_q     (reg_q),
    .locked0   (locked0)
  );

  always #5 clk0 = ~clk0;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mdl [ND];
  int            win;
  bit            p_vld, p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_din;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] image();
    logic [W-1:0] v;
    for (int i = 0; i < ND; i++)
      v[i*DW +: DW] = RO_M[i] ? hw_ro_val[i*DW +: DW] : mdl[i];
    return v;
  endfunction

  function automatic logic exp_locked();
`ifdef UPDI_REG_LOCK_EN
    return (win == 0);
`else
    return 1'b0;
`endif
  endfunction

  // Effect of the request captured one edge earlier, evaluated at its execute edge.
  task automatic model_exec(input logic [W-1:0] hs, output bit rv, output bit ae, output logic [DW-1:0] dv);
    int a, wa;
    bit lk;
    rv = 0; ae = 0; dv = '0; wa = -1;
    a  = int'(p_addr);
    lk = exp_locked();
    if (win > 0) win--;
    if (p_vld) begin
      if (a >= ND) begin
        ae = 1; rv = !p_we; dv = '0;
      end
`ifdef UPDI_REG_LOCK_EN
      else if (a == KEY_A) begin
        if (p_we) win = (p_din == 8'hC5) ? UNLOCK : 0;
        else begin rv = 1; dv = {7'b0, lk}; end
      end
`endif
      else if (!p_we) begin
        rv = 1;
        dv = RO_M[a] ? hw_ro_val[a*DW +: DW] : mdl[a];
      end
      else if (RO_M[a]) ae = 1;
`ifdef UPDI_REG_LOCK_EN
      else if (PROT_M[a] && lk) ae = 1;
`endif
      else begin
        wa = a;
`ifdef UPDI_REG_LOCK_EN
        if (PROT_M[a]) win = 0;
`endif
      end
    end
    for (int i = 0; i < ND; i++) begin
      if (W1C_M[i])
        mdl[i] = ((i == wa) ? (mdl[i] & ~p_din) : mdl[i]) | hs[i*DW +: DW];
      else if (!RO_M[i] && i == wa)
        mdl[i] = p_din;
    end
  endtask

  task automatic step(input logic csb, input logic web, input logic [AW-1:0] addr,
                      input logic [DW-1:0] din, input logic [W-1:0] hs);
    bit exp_rv, exp_ae;
    logic [DW-1:0] exp_do;
    bus.csb0 = csb; bus.web0 = web; bus.addr0 = addr; bus.din0 = din;
    hw_set = hs;
    model_exec(hs, exp_rv, exp_ae, exp_do);
    p_vld = !csb; p_we = !web; p_addr = addr; p_din = din;
    @(posedge clk0); #1;
    chk("rvalid0", bus.rvalid0, exp_rv);
    chk("aerr0", bus.aerr0, exp_ae);
    if (exp_rv) chk("dout0", bus.dout0, exp_do);
    chk("reg_q", reg_q, image());
    chk("locked0", locked0, exp_locked());
  endtask

  task automatic do_reset();
    rst0_n = 1'b0;
    bus.csb0 = 1'b1; bus.web0 = 1'b1; bus.addr0 = '0; bus.din0 = '0;
    hw_set = '0;
    for (int i = 0; i < ND; i++) mdl[i] = RST_IMG[i*DW +: DW];
    win = 0; p_vld = 0; p_we = 0; p_addr = '0; p_din = '0;
    @(posedge clk0); #1;
    chk("rst_rvalid0", bus.rvalid0, 1'b0);
    chk("rst_aerr0", bus.aerr0, 1'b0);
    chk("rst_dout0", bus.dout0, 8'h00);
    chk("rst_reg_q", reg_q, image());
    chk("rst_locked0", locked0, exp_locked());
    rst0_n = 1'b1;
  endtask

  function automatic logic [W-1:0] slice(input int idx, input logic [DW-1:0] v);
    logic [W-1:0] r;
    r = '0;
    r[idx*DW +: DW] = v;
    return r;
  endfunction

  initial begin
    do_reset();

    // Reset value readback and 2-edge latency
    step(1'b0, 1'b1, 4'h3, 8'h00, '0);
    step(1'b1, 1'b1, 4'h0, 8'h00, '0);

    // RW write then back-to-back reads
    step(1'b0, 1'b0, 4'h2, 8'hA5, '0);
    step(1'b0, 1'b1, 4'h2, 8'h00, '0);
    step(1'b0, 1'b0, 4'h2, 8'h3C, '0);
    step(1'b0, 1'b1, 4'h2, 8'h00, '0);
    step(1'b1, 1'b1, 4'h0, 8'h00, '0);

    // W1C: set, clear, set-wins
    step(1'b1, 1'b1, 4'h0, 8'h00, slice(1, 8'h06));
    step(1'b0, 1'b1, 4'h1, 8'h00, '0);
    step(1'b0, 1'b0, 4'h1, 8'h02, '0);
    step(1'b0, 1'b1, 4'h1, 8'h00, '0);
    step(1'b0, 1'b0, 4'h1, 8'h04, '0);
    step(1'b0, 1'b1, 4'h1, 8'h00, slice(1, 8'h04));
    step(1'b1, 1'b1, 4'h0, 8'h00, '0);

    // RO: refused write, live readback
    hw_ro_val = slice(0, 8'h3C) | slice(6, 8'h9E);
    step(1'b0, 1'b0, 4'h0, 8'hFF, '0);
    step(1'b0, 1'b1, 4'h0, 8'h00, '0);
    step(1'b1, 1'b1, 4'h0, 8'h00, '0);

    // Out-of-range read and write
    step(1'b0, 1'b1, 4'hE, 8'h00, '0);
    step(1'b0, 1'b0, 4'hE, 8'hFF, '0);
    step(1'b0, 1'b0, 4'hF, 8'h55, '0);
    step(1'b1, 1'b1, 4'h0, 8'h00, '0);

`ifdef UPDI_REG_LOCK_EN
    // Locked write refused, key opens, protected write closes
    step(1'b0, 1'b0, 4'h5, 8'h11, '0);
    step(1'b0, 1'b0, 4'hC, 8'hC5, '0);
    step(1'b0, 1'b0, 4'h5, 8'h11, '0);
    step(1'b0, 1'b1, 4'hC, 8'h00, '0);
    step(1'b1, 1'b1, 4'h0, 8'h00, '0);
    // Window expiry
    step(1'b0, 1'b0, 4'hC, 8'hC5, '0);
    for (int i = 0; i < UNLOCK + 2; i++) step(1'b1, 1'b1, 4'h0, 8'h00, '0);
    step(1'b0, 1'b0, 4'h5, 8'h22, '0);
    step(1'b1, 1'b1, 4'h0, 8'h00, '0);
    // Wrong key closes, reset during open window relocks
    step(1'b0, 1'b0, 4'hC, 8'hC5, '0);
    step(1'b0, 1'b0, 4'hC, 8'h12, '0);
    step(1'b0, 1'b0, 4'hC, 8'hC5, '0);
    step(1'b1, 1'b1, 4'h0, 8'h00, '0);
    do_reset();
    step(1'b1, 1'b1, 4'h0, 8'h00, '0);
`endif

    // Reset between capture and execute drops the request
    step(1'b0, 1'b1, 4'h3, 8'h00, '0);
    do_reset();
    step(1'b1, 1'b1, 4'h0, 8'h00, '0);
    step(1'b1, 1'b1, 4'h0, 8'h00, '0);

    for (int k = 0; k < 800; k++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [W-1:0]  hs;
      logic          cs, wb;
      a  = AW'($urandom_range(0, 15));
      d  = DW'($urandom);
      cs = ($urandom_range(0, 4) == 0);
      wb = 1'($urandom_range(0, 1));
      hs = '0;
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < ND; i++) hs[i*DW +: DW] = DW'($urandom) & DW'($urandom);
      if ($urandom_range(0, 15) == 0)
        for (int i = 0; i < ND; i++) hw_ro_val[i*DW +: DW] = DW'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        a = 4'hC; d = 8'hC5; wb = 1'b0; cs = 1'b0;
      end
      step(cs, wb, a, d, hs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
